// File: rtl/tcb_lib_byteena2logsize_if.sv
// Request/response bundle between a byte-enable TCB manager and a log-size
// TCB subordinate, with the bridge sitting in between.
// slave  : the bridge (subordinate on the sub_* side, manager on the man_* side)
// master : the surroundings (drives sub_* requests and man_* responses)
interface tcb_lib_byteena2logsize_if #(
  parameter int unsigned ADR = 32,
  parameter int unsigned BEN = 4
);
  localparam int unsigned MAX = $clog2(BEN);
  localparam int unsigned SIZ = (MAX > 0) ? $clog2(MAX + 1) : 1;

  // byte-enable side
  logic               sub_vld;
  logic               sub_rdy;
  logic               sub_wen;
  logic [ADR-1:0]     sub_adr;
  logic [BEN-1:0]     sub_ben;
  logic [8*BEN-1:0]   sub_wdt;
  logic [8*BEN-1:0]   sub_rdt;
  logic               sub_sts;

  // log-size side
  logic               man_vld;
  logic               man_rdy;
  logic               man_wen;
  logic [ADR-1:0]     man_adr;
  logic [SIZ-1:0]     man_siz;
  logic [8*BEN-1:0]   man_wdt;
  logic [8*BEN-1:0]   man_rdt;
  logic               man_sts;

  modport slave (
    input  sub_vld, sub_wen, sub_adr, sub_ben, sub_wdt,
    output sub_rdy, sub_rdt, sub_sts,
    output man_vld, man_wen, man_adr, man_siz, man_wdt,
    input  man_rdy, man_rdt, man_sts
  );

  modport master (
    output sub_vld, sub_wen, sub_adr, sub_ben, sub_wdt,
    input  sub_rdy, sub_rdt, sub_sts,
    input  man_vld, man_wen, man_adr, man_siz, man_wdt,
    output man_rdy, man_rdt, man_sts
  );
endinterface

// File: rtl/tcb_lib_byteena2logsize.sv
// Byte-enable to log-size TCB bridge. Each request is split into naturally
// aligned power-of-two pieces (lowest enabled byte first); piece responses are
// merged back into a single byte-enable response.
module tcb_lib_byteena2logsize #(
  parameter int unsigned ADR = 32,
  parameter int unsigned BEN = 4,
  parameter int unsigned DLY = 1
) (
  input logic                         clk,
  input logic                         rst,
  tcb_lib_byteena2logsize_if.slave    tcb
);
  localparam int unsigned MAX = $clog2(BEN);
  localparam int unsigned SIZ = (MAX > 0) ? $clog2(MAX + 1) : 1;
  localparam int unsigned DW  = 8 * BEN;

  // splitter state
  logic           busy_q;
  logic [BEN-1:0] rem_q;

  // piece selection
  logic [BEN-1:0] cur;
  logic [BEN-1:0] pmask;
  logic [BEN-1:0] chk;
  logic [MAX-1:0] off;
  logic [SIZ-1:0] siz;
  logic           last;
  logic           zero_req;
  logic           man_xfer;
  logic           zero_xfer;
  logic [DW-1:0]  wdt_sh;

  // response pipeline, entry DLY-1 is the one whose response is on man_rdt
  logic [DLY-1:0]          pv_q;
  logic [DLY-1:0]          pw_q;
  logic [DLY-1:0]          pz_q;
  logic [DLY-1:0]          pl_q;
  logic [DLY-1:0][MAX-1:0] po_q;
  logic [DLY-1:0][SIZ-1:0] ps_q;

  // merge state
  logic [DW-1:0]  mrg_buf_q;
  logic           sts_acc_q;
  logic [DW-1:0]  rdt_sh;
  logic [DW-1:0]  mrg;
  logic           sts_m;
  logic           out_last;
  logic [MAX-1:0] out_off;
  logic [SIZ-1:0] out_siz;

  // Pick the lowest enabled byte and grow the chunk while it stays aligned and enabled.
  always_comb begin
    cur = busy_q ? rem_q : tcb.sub_ben;
    off = '0;
    for (int i = BEN - 1; i >= 0; i--) begin
      if (cur[i]) off = MAX'(i);
    end
    siz      = '0;
    pmask    = '0;
    pmask[off] = 1'b1;
    chk      = '0;
    for (int s = 1; s <= MAX; s++) begin
      for (int b = 0; b < BEN; b++) begin
        chk[b] = (b >= int'(off)) && (b < int'(off) + (1 << s));
      end
      if (((int'(off) & ((1 << s) - 1)) == 0) && ((cur & chk) == chk)) begin
        siz   = SIZ'(s);
        pmask = chk;
      end
    end
  end

  // Manager request fields and subordinate ready.
  always_comb begin
    last     = ((cur & ~pmask) == '0);
    zero_req = !busy_q && (tcb.sub_ben == '0);

    tcb.man_vld = tcb.sub_vld && (cur != '0);
    tcb.man_wen = tcb.sub_wen;
    tcb.man_adr = {tcb.sub_adr[ADR-1:MAX], off};
    tcb.man_siz = siz;

    wdt_sh      = tcb.sub_wdt >> (8 * int'(off));
    tcb.man_wdt = '0;
    for (int j = 0; j < BEN; j++) begin
      if (j < (1 << siz)) tcb.man_wdt[8*j +: 8] = wdt_sh[8*j +: 8];
    end

    // a zero-mask request is acknowledged locally without a manager transfer
    tcb.sub_rdy = zero_req ? 1'b1 : (tcb.man_rdy && last);
    man_xfer    = tcb.man_vld && tcb.man_rdy;
    zero_xfer   = tcb.sub_vld && zero_req;
  end

  // Track the bytes still to be sent while a request is being split.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      rem_q  <= '0;
    end else if (man_xfer) begin
      busy_q <= !last;
      rem_q  <= last ? '0 : (cur & ~pmask);
    end
  end

  // Shift piece descriptors along so they line up with their delayed responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q <= '0;
      pw_q <= '0;
      pz_q <= '0;
      pl_q <= '0;
      po_q <= '0;
      ps_q <= '0;
    end else begin
      for (int i = DLY - 1; i > 0; i--) begin
        pv_q[i] <= pv_q[i-1];
        pw_q[i] <= pw_q[i-1];
        pz_q[i] <= pz_q[i-1];
        pl_q[i] <= pl_q[i-1];
        po_q[i] <= po_q[i-1];
        ps_q[i] <= ps_q[i-1];
      end
      pv_q[0] <= man_xfer || zero_xfer;
      pw_q[0] <= tcb.sub_wen;
      pz_q[0] <= zero_xfer;
      pl_q[0] <= last;
      po_q[0] <= off;
      ps_q[0] <= siz;
    end
  end

  // Fold the current piece response into the partial word and status.
  always_comb begin
    out_off = po_q[DLY-1];
    out_siz = ps_q[DLY-1];
    rdt_sh  = tcb.man_rdt << (8 * int'(out_off));
    mrg     = mrg_buf_q;
    if (!pw_q[DLY-1] && !pz_q[DLY-1]) begin
      for (int b = 0; b < BEN; b++) begin
        if ((b >= int'(out_off)) && (b < int'(out_off) + (1 << out_siz))) begin
          mrg[8*b +: 8] = rdt_sh[8*b +: 8];
        end
      end
    end
    // zero-mask entries have no manager response behind them
    sts_m       = sts_acc_q | (tcb.man_sts & ~pz_q[DLY-1]);
    out_last    = pv_q[DLY-1] & pl_q[DLY-1];
    tcb.sub_rdt = out_last ? mrg : '0;
    tcb.sub_sts = out_last & sts_m;
  end

  // Hold partial results between pieces; clear once the final piece is delivered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mrg_buf_q <= '0;
      sts_acc_q <= 1'b0;
    end else if (pv_q[DLY-1]) begin
      if (pl_q[DLY-1]) begin
        mrg_buf_q <= '0;
        sts_acc_q <= 1'b0;
      end else begin
        mrg_buf_q <= mrg;
        sts_acc_q <= sts_m;
      end
    end
  end

endmodule

// File: tb/tb_tcb_lib_byteena2logsize.sv
// Bench for the byte-enable to log-size bridge. A behavioural manager-side
// responder returns bytes of rd_word and flags errors on bytes in err_ben;
// expected pieces and responses come from a greedy split of the byte mask.
module tb_tcb_lib_byteena2logsize;
  localparam int ADR = 32;
  localparam int BEN = 4;
  localparam int DLY = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tcb_lib_byteena2logsize_if #(.ADR(ADR), .BEN(BEN)) bus ();

  tcb_lib_byteena2logsize #(.ADR(ADR), .BEN(BEN), .DLY(DLY)) dut (
    .clk (clk),
    .rst (rst),
    .tcb (bus)
  );

  int checks   = 0;
  int failures = 0;

  // observed manager pieces and subordinate responses
  logic [31:0] pc_adr[$];
  int          pc_siz[$];
  logic [31:0] pc_wdt[$];
  logic        pc_wen[$];
  logic [31:0] rs_rdt[$];
  logic        rs_sts[$];

  // model expectations
  logic [31:0] ex_adr[$];
  int          ex_siz[$];
  logic [31:0] ex_wdt[$];
  logic [31:0] ex_rdt[$];
  logic        ex_sts[$];

  // responder memory
  logic [31:0] rd_word = 32'h0;
  logic [3:0]  err_ben = 4'h0;

  logic        resp_due = 1'b0;
  int          idle_bad = 0;
  int          stab_bad = 0;
  logic        st_vld   = 1'b0;
  logic [31:0] st_adr, st_wdt;
  logic [1:0]  st_siz;
  logic        st_wen;

  // Greedy split: lowest enabled byte, largest aligned fully enabled chunk.
  function automatic void model(input logic [3:0] ben, input logic [31:0] adr,
                                input logic [31:0] wdt);
    logic [3:0]  rem;
    logic [3:0]  pm;
    logic [63:0] bm;
    int          o;
    int          s;
    int          n;
    ex_adr.delete(); ex_siz.delete(); ex_wdt.delete();
    rem = ben;
    while (rem != 4'h0) begin
      o = 0;
      while (!rem[o]) o++;
      for (s = 2; s >= 0; s--) begin
        n  = 1 << s;
        pm = 4'(((1 << n) - 1) << o);
        if ((o % n) == 0 && (rem & pm) == pm) break;
      end
      bm = (64'd1 << (8 * n)) - 64'd1;
      ex_adr.push_back({adr[31:2], 2'b00} + 32'(o));
      ex_siz.push_back(s);
      ex_wdt.push_back(32'((wdt >> (8 * o)) & bm[31:0]));
      rem = rem & ~pm;
    end
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] ben);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{ben[i]}};
    return m;
  endfunction

  // One clock: sample at negedge, then answer the piece (if any) after the edge.
  task automatic step(output logic hs, output logic xfer);
    logic [1:0]  o;
    int          n;
    logic [63:0] bm;
    logic [3:0]  pm;
    @(negedge clk);
    if (resp_due) begin
      rs_rdt.push_back(bus.sub_rdt);
      rs_sts.push_back(bus.sub_sts);
      resp_due = 1'b0;
    end else if (bus.sub_rdt !== 32'h0 || bus.sub_sts !== 1'b0) begin
      idle_bad++;
    end
    if (bus.man_vld && !bus.man_rdy) begin
      if (st_vld && (bus.man_adr !== st_adr || bus.man_siz !== st_siz ||
                     bus.man_wdt !== st_wdt || bus.man_wen !== st_wen)) stab_bad++;
      st_vld = 1'b1;
      st_adr = bus.man_adr; st_siz = bus.man_siz; st_wdt = bus.man_wdt; st_wen = bus.man_wen;
    end else begin
      st_vld = 1'b0;
    end
    xfer = bus.man_vld && bus.man_rdy;
    hs   = bus.sub_vld && bus.sub_rdy;
    o    = bus.man_adr[1:0];
    n    = 1 << bus.man_siz;
    if (xfer) begin
      pc_adr.push_back(bus.man_adr);
      pc_siz.push_back(int'(bus.man_siz));
      pc_wdt.push_back(bus.man_wdt);
      pc_wen.push_back(bus.man_wen);
    end
    @(posedge clk);
    #1;
    resp_due = hs;
    if (xfer) begin
      bm = (64'd1 << (8 * n)) - 64'd1;
      pm = 4'(((1 << n) - 1) << o);
      bus.man_rdt = 32'((rd_word >> (8 * o)) & bm[31:0]);
      bus.man_sts = |(err_ben & pm);
    end else begin
      bus.man_rdt = $urandom;
      bus.man_sts = 1'b1;
    end
  endtask

  // Present one request until it is accepted; man_rdy held low `stall` cycles per piece.
  task automatic run_req(input logic wen, input logic [31:0] adr, input logic [3:0] ben,
                         input logic [31:0] wdt, input int stall, output int cycles);
    logic hs;
    logic xfer;
    int   sc;
    pc_adr.delete(); pc_siz.delete(); pc_wdt.delete(); pc_wen.delete();
    bus.sub_vld = 1'b1;
    bus.sub_wen = wen;
    bus.sub_adr = adr;
    bus.sub_ben = ben;
    bus.sub_wdt = wdt;
    sc     = stall;
    cycles = 0;
    hs     = 1'b0;
    while (!hs && cycles < 40) begin
      bus.man_rdy = (sc == 0);
      step(hs, xfer);
      cycles++;
      if (xfer) sc = stall;
      else if (sc > 0) sc--;
    end
    checks++;
    if (!hs) begin
      failures++;
      $display("FAIL req_accept: ben=%b not accepted within %0d cycles", ben, cycles);
    end
  endtask

  task automatic idle();
    logic hs;
    logic xfer;
    bus.sub_vld = 1'b0;
    bus.sub_ben = 4'($urandom);
    bus.man_rdy = 1'b1;
    step(hs, xfer);
  endtask

  task automatic test_reset();
    bus.sub_vld = 1'b1; bus.sub_ben = 4'hF; bus.man_sts = 1'b1; bus.man_rdt = 32'hFFFF_FFFF;
    #2;
    checks++; if (bus.sub_rdt !== 32'h0) begin failures++; $display("FAIL reset_rdt: got %h want 0", bus.sub_rdt); end
    checks++; if (bus.sub_sts !== 1'b0) begin failures++; $display("FAIL reset_sts: got %b want 0", bus.sub_sts); end
    checks++; if (bus.man_adr[1:0] !== 2'd0 || bus.man_siz !== 2'd2) begin failures++;
      $display("FAIL reset_piece: off=%0d siz=%0d want 0/2", bus.man_adr[1:0], bus.man_siz); end
    bus.sub_vld = 1'b0; bus.sub_ben = 4'h0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.man_vld !== 1'b0) begin failures++; $display("FAIL reset_man_vld: got %b want 0", bus.man_vld); end
    checks++; if (bus.sub_rdy !== 1'b1) begin failures++; $display("FAIL reset_sub_rdy: got %b want 1", bus.sub_rdy); end
  endtask

  task automatic test_single_read();
    int cyc;
    rs_rdt.delete(); rs_sts.delete();
    rd_word = 32'hDDCC_BBAA; err_ben = 4'h0;
    run_req(1'b0, 32'h100, 4'hF, $urandom, 0, cyc);
    idle();
    checks++; if (cyc != 1) begin failures++; $display("FAIL single_latency: got %0d want 1", cyc); end
    checks++; if (pc_adr.size() != 1 || pc_adr[0] !== 32'h100 || pc_siz[0] != 2) begin failures++;
      $display("FAIL single_piece: n=%0d adr=%h siz=%0d want 1/100/2", pc_adr.size(), pc_adr[0], pc_siz[0]); end
    checks++; if (rs_rdt.size() != 1 || rs_rdt[0] !== 32'hDDCC_BBAA || rs_sts[0] !== 1'b0) begin failures++;
      $display("FAIL single_rdt: got %h/%b want ddccbbaa/0", rs_rdt[0], rs_sts[0]); end
  endtask

  task automatic test_write_split();
    int          cyc;
    logic [31:0] ea[2];
    logic [31:0] ew[2];
    ea = '{32'h205, 32'h207};
    ew = '{32'h22, 32'h44};
    rs_rdt.delete(); rs_sts.delete();
    rd_word = $urandom; err_ben = 4'h0;
    run_req(1'b1, 32'h204, 4'b1010, 32'h4433_2211, 0, cyc);
    idle();
    checks++; if (cyc != 2) begin failures++; $display("FAIL write_rdy_cycle: got %0d want 2", cyc); end
    checks++; if (pc_adr.size() != 2) begin failures++; $display("FAIL write_npieces: got %0d want 2", pc_adr.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= pc_adr.size() || pc_adr[i] !== ea[i] || pc_siz[i] != 0 || pc_wdt[i] !== ew[i] ||
          pc_wen[i] !== 1'b1) begin
        failures++;
        $display("FAIL write_piece%0d: adr=%h siz=%0d wdt=%h want %h/0/%h", i, pc_adr[i], pc_siz[i],
                 pc_wdt[i], ea[i], ew[i]);
      end
    end
    checks++; if (rs_rdt.size() != 1 || rs_rdt[0] !== 32'h0 || rs_sts[0] !== 1'b0) begin failures++;
      $display("FAIL write_resp: got %h/%b want 0/0", rs_rdt[0], rs_sts[0]); end
  endtask

  task automatic test_read_split();
    int cyc;
    rs_rdt.delete(); rs_sts.delete();
    rd_word = 32'hDDCC_BBAA; err_ben = 4'h0;
    run_req(1'b0, 32'h340, 4'b0111, $urandom, 0, cyc);
    idle();
    checks++; if (pc_adr.size() != 2 || pc_adr[0] !== 32'h340 || pc_siz[0] != 1 ||
                  pc_adr[1] !== 32'h342 || pc_siz[1] != 0) begin failures++;
      $display("FAIL read_pieces: n=%0d %h/%0d %h/%0d want 340/1 342/0", pc_adr.size(), pc_adr[0],
               pc_siz[0], pc_adr[1], pc_siz[1]); end
    checks++; if (rs_rdt.size() != 1 || rs_rdt[0] !== 32'h00CC_BBAA) begin failures++;
      $display("FAIL read_merge: got %h want 00ccbbaa", rs_rdt[0]); end
    rs_rdt.delete(); rs_sts.delete();
    run_req(1'b0, 32'h500, 4'b0110, $urandom, 0, cyc);
    idle();
    checks++; if (pc_adr.size() != 2 || pc_adr[0] !== 32'h501 || pc_siz[0] != 0 ||
                  pc_adr[1] !== 32'h502 || pc_siz[1] != 0) begin failures++;
      $display("FAIL unaligned_pieces: n=%0d %h/%0d %h/%0d want 501/0 502/0", pc_adr.size(),
               pc_adr[0], pc_siz[0], pc_adr[1], pc_siz[1]); end
    checks++; if (rs_rdt.size() != 1 || rs_rdt[0] !== 32'h00CC_BB00) begin failures++;
      $display("FAIL unaligned_merge: got %h want 00ccbb00", rs_rdt[0]); end
  endtask

  task automatic test_stall_error();
    int cyc;
    rs_rdt.delete(); rs_sts.delete();
    stab_bad = 0;
    rd_word = 32'h8877_6655; err_ben = 4'b1000;
    run_req(1'b0, 32'h600, 4'b1011, $urandom, 3, cyc);
    idle();
    checks++; if (cyc != 8) begin failures++; $display("FAIL stall_cycles: got %0d want 8", cyc); end
    checks++; if (stab_bad != 0) begin failures++; $display("FAIL stall_stable: changes=%0d want 0", stab_bad); end
    checks++; if (pc_adr.size() != 2 || pc_adr[0] !== 32'h600 || pc_siz[0] != 1 ||
                  pc_adr[1] !== 32'h603 || pc_siz[1] != 0) begin failures++;
      $display("FAIL stall_pieces: n=%0d %h/%0d %h/%0d want 600/1 603/0", pc_adr.size(), pc_adr[0],
               pc_siz[0], pc_adr[1], pc_siz[1]); end
    checks++; if (rs_rdt.size() != 1 || rs_rdt[0] !== 32'h8800_6655 || rs_sts[0] !== 1'b1) begin
      failures++; $display("FAIL stall_resp: got %h/%b want 88006655/1", rs_rdt[0], rs_sts[0]); end
  endtask

  task automatic test_zero_ben();
    int cyc;
    rs_rdt.delete(); rs_sts.delete();
    err_ben = 4'hF;
    run_req(1'b0, 32'h700, 4'h0, $urandom, 2, cyc);
    idle();
    checks++; if (cyc != 1 || pc_adr.size() != 0) begin failures++;
      $display("FAIL zero_handshake: cycles=%0d pieces=%0d want 1/0", cyc, pc_adr.size()); end
    checks++; if (rs_rdt.size() != 1 || rs_rdt[0] !== 32'h0 || rs_sts[0] !== 1'b0) begin failures++;
      $display("FAIL zero_resp: got %h/%b want 0/0", rs_rdt[0], rs_sts[0]); end
  endtask

  task automatic test_reset_mid();
    logic hs;
    logic xfer;
    int   cyc;
    rs_rdt.delete(); rs_sts.delete();
    err_ben = 4'h0; rd_word = 32'h4433_2211;
    bus.sub_vld = 1'b1; bus.sub_wen = 1'b0; bus.sub_adr = 32'h800; bus.sub_ben = 4'b0101;
    bus.man_rdy = 1'b1;
    step(hs, xfer);
    checks++; if (bus.man_vld !== 1'b1 || bus.man_adr !== 32'h802) begin failures++;
      $display("FAIL mid_second_piece: vld=%b adr=%h want 1/802", bus.man_vld, bus.man_adr); end
    rst = 1'b0;
    #1;
    checks++; if (bus.man_adr !== 32'h800) begin failures++;
      $display("FAIL mid_reset_restart: adr=%h want 800", bus.man_adr); end
    bus.sub_vld = 1'b0;
    #1;
    checks++; if (bus.man_vld !== 1'b0) begin failures++; $display("FAIL mid_reset_vld: got %b want 0", bus.man_vld); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_req(1'b0, 32'h900, 4'b1100, $urandom, 0, cyc);
    idle();
    checks++; if (pc_adr.size() != 1 || pc_adr[0] !== 32'h902 || pc_siz[0] != 1) begin failures++;
      $display("FAIL mid_next_piece: n=%0d adr=%h siz=%0d want 1/902/1", pc_adr.size(), pc_adr[0], pc_siz[0]); end
    checks++; if (rs_rdt.size() != 1 || rs_rdt[0] !== 32'h4433_0000) begin failures++;
      $display("FAIL mid_next_resp: got %h want 44330000", rs_rdt[0]); end
  endtask

  task automatic test_back_to_back();
    int          cyc;
    logic        wen;
    logic [31:0] adr;
    logic [31:0] wdt;
    logic [3:0]  ben;
    rs_rdt.delete(); rs_sts.delete(); ex_rdt.delete(); ex_sts.delete();
    stab_bad = 0;
    for (int k = 0; k < 60; k++) begin
      wen = 1'($urandom); adr = $urandom; wdt = $urandom; ben = 4'($urandom);
      rd_word = $urandom; err_ben = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      model(ben, adr, wdt);
      ex_rdt.push_back(wen ? 32'h0 : (rd_word & byte_mask(ben)));
      ex_sts.push_back(|(err_ben & ben));
      run_req(wen, adr, ben, wdt, ($urandom_range(0, 3) == 0) ? 2 : 0, cyc);
      checks++;
      if (pc_adr.size() != ex_adr.size()) begin
        failures++;
        $display("FAIL b2b_npieces[%0d]: ben=%b got %0d want %0d", k, ben, pc_adr.size(), ex_adr.size());
      end
      for (int i = 0; i < ex_adr.size() && i < pc_adr.size(); i++) begin
        checks++;
        if (pc_adr[i] !== ex_adr[i] || pc_siz[i] != ex_siz[i] || pc_wdt[i] !== ex_wdt[i] ||
            pc_wen[i] !== wen) begin
          failures++;
          $display("FAIL b2b_piece[%0d.%0d]: got %h/%0d/%h want %h/%0d/%h", k, i, pc_adr[i],
                   pc_siz[i], pc_wdt[i], ex_adr[i], ex_siz[i], ex_wdt[i]);
        end
      end
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    checks++;
    if (rs_rdt.size() != ex_rdt.size()) begin
      failures++; $display("FAIL b2b_nresp: got %0d want %0d", rs_rdt.size(), ex_rdt.size());
    end
    for (int i = 0; i < ex_rdt.size() && i < rs_rdt.size(); i++) begin
      checks++;
      if (rs_rdt[i] !== ex_rdt[i] || rs_sts[i] !== ex_sts[i]) begin
        failures++;
        $display("FAIL b2b_resp[%0d]: got %h/%b want %h/%b", i, rs_rdt[i], rs_sts[i], ex_rdt[i], ex_sts[i]);
      end
    end
    checks++; if (stab_bad != 0) begin failures++; $display("FAIL b2b_stable: changes=%0d want 0", stab_bad); end
  endtask

  initial begin
    bus.sub_vld = 1'b0; bus.sub_wen = 1'b0; bus.sub_adr = '0; bus.sub_ben = '0; bus.sub_wdt = '0;
    bus.man_rdy = 1'b1; bus.man_rdt = '0; bus.man_sts = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_single_read();
    test_write_split();
    test_read_split();
    test_stall_error();
    test_zero_ben();
    test_reset_mid();
    test_back_to_back();
    checks++; if (idle_bad != 0) begin failures++; $display("FAIL idle_resp: nonzero idle cycles=%0d want 0", idle_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule

// File: doc/tcb_lib_byteena2logsize.md
Name: tcb_lib_byteena2logsize

Overview:
- Converts a TCB byte-enable mode request stream (subordinate side) into a TCB logarithmic-size mode stream (manager side).
- Lets byte-enable managers (CPU store units, DMA) reach log-size peripherals.
- Byte-enable patterns that are not one naturally aligned power-of-two chunk are split into a sequence of log-size transfers.
- Read data and status from all pieces are merged into one subordinate response.

Parameters:
- ADR, 32, address width.
- BEN, 4, bytes per data word (power of two); MAX = log2(BEN), SIZ = clog2(MAX+1).
- DLY, 1, fixed response delay in cycles on both ports; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- sub_vld  in  1  request valid.
- sub_rdy  out  1  request ready.
- sub_wen  in  1  write enable; 0 means read.
- sub_adr  in  ADR  byte address; the low MAX bits are ignored.
- sub_ben  in  BEN  byte enables.
- sub_wdt  in  8*BEN  write data, byte i at lane i.
- sub_rdt  out  8*BEN  read data.
- sub_sts  out  1  error status.
- man_vld  out  1  request valid.
- man_rdy  in  1  request ready.
- man_wen  out  1  write enable.
- man_adr  out  ADR  byte address of the current piece.
- man_siz  out  SIZ  log2 of the piece size in bytes.
- man_wdt  out  8*BEN  piece write data, LSB-justified.
- man_rdt  in  8*BEN  piece read data, LSB-justified.
- man_sts  in  1  piece error status.

Behaviour:
- Handshake: a transfer occurs when vld & rdy. The sub manager holds all request fields stable while vld & !rdy. Responses appear exactly DLY cycles after a transfer.
- State:
  - busy (reset 0).
  - rem[BEN] remaining mask (reset 0).
  - Response pipeline of DLY entries {vld, wen, off, siz, last} (reset all 0).
  - Merge buffer buf[8*BEN] (reset 0) and sts_acc (reset 0).
- Current mask: cur = busy ? rem : sub_ben.
- Piece selection (combinational):
  - off = index of the lowest set bit of cur.
  - siz = largest s ≤ MAX such that off mod 2^s == 0 and cur bits off..off+2^s-1 are all set.
  - pmask = the bits of that chunk.
- Manager request outputs:
  - man_vld = sub_vld & (cur != 0).
  - man_adr = {sub_adr[ADR-1:MAX], off}.
  - man_siz = siz.
  - man_wen = sub_wen.
  - man_wdt byte j = sub_wdt byte off+j for j < 2^siz; other bytes 0.
- last = ((cur & ~pmask) == 0).
- sub_rdy:
  - cur != 0: sub_rdy = man_rdy & last.
  - sub_ben == 0 with !busy: sub_rdy = 1 and no manager transfer. The response returns rdt = 0, sts = 0 after DLY cycles.
- On a manager transfer:
  - If last: busy <= 0, rem <= 0.
  - Otherwise: busy <= 1, rem <= cur & ~pmask.
- Latency: a single-piece request is zero added cycles (pass-through). An N-piece request occupies N manager transfers, gapless when man_rdy = 1.
- Response pipeline: each manager transfer (and each ben == 0 handshake, with a zero-mask entry) pushes an entry. At pipeline output (DLY cycles later), with a valid entry:
  - Form mrg = buf with bytes off..off+2^siz-1 replaced by man_rdt bytes 0..2^siz-1 (reads only; writes leave buf unchanged).
  - Form sts_m = sts_acc | man_sts.
  - Not last: buf <= mrg, sts_acc <= sts_m.
  - Last: sub_rdt = mrg, sub_sts = sts_m, then buf <= 0 and sts_acc <= 0.
- Bytes not enabled read as 0. When no last entry is at the output, sub_rdt = 0 and sub_sts = 0.
- Write pieces contribute only sts; their sub_rdt is 0.
- man_sts from pieces is ORed, so any erroring piece yields sub_sts = 1.
- The next sub request may be accepted in the cycle after the last piece transfers. The pipeline depth keeps overlapping responses ordered.
- Reset asserted mid-sequence: busy, rem, pipeline, buf and sts_acc clear immediately. Outstanding responses are discarded; man_vld then follows the new cur.
- Endianness: little only. The addressing is aligned word-based; no cross-word pieces.

Test Plan:
- Read, adr 0x100, ben 1111, man_rdy = 1.
  - Required: one transfer, adr 0x100, siz 2, sub_rdy same cycle.
  - man_rdt 0xDDCCBBAA → sub_rdt 0xDDCCBBAA one cycle later.
- Write, adr 0x204, ben 1010, wdt 0x44332211.
  - Required: piece 1 is adr 0x205, siz 0, wdt 0x00000022; piece 2 is adr 0x207, siz 0, wdt 0x00000044.
  - sub_rdy is high only in the second cycle.
- Read, ben 0111.
  - Required: piece 1 is adr+0, siz 1, rdt 0x0000BBAA; piece 2 is adr+2, siz 0, rdt 0x000000CC.
  - sub_rdt = 0x00CCBBAA one cycle after the second transfer.
- ben 0110.
  - Required: two byte pieces at off 1 and off 2 (off 1 is not halfword aligned).
- ben 1011 with man_rdy low for 3 cycles before each piece.
  - Required: man fields stable while stalled; sub_rdy pulses once.
  - Second piece (byte, off 3) returns man_sts = 1 → sub_sts = 1.
- Two further cases:
  - ben 0000 → no man_vld, sub_rdy = 1, sub_rdt = 0, sub_sts = 0.
  - Reset asserted after the first piece of ben 0101 → man_vld drops, and the next request starts cleanly from its own lowest set bit.
